// File: rtl/pic_exec_core.sv
// Execute stage of the 8-bit PIC-style core.
// Decodes the instruction, selects the ALU B operand (file f or literal k),
// computes the 8-bit result from W and B, and holds the C/Z flags.
module pic_exec_core (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] inst_reg,
  input  logic [7:0] f,
  input  logic [7:0] k,
  input  logic [7:0] w,
  output logic [7:0] ans,
  output logic       d,
  output logic       carry,
  output logic       zero,
  output logic [3:0] inst,
  output logic [2:0] bit_number,
  output logic       switch_a_m,
  output logic [7:0] b
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_IOR   = 4'h3,
    OP_XOR   = 4'h4, OP_COM  = 4'h5, OP_CLR  = 4'h6, OP_MOV   = 4'h7,
    OP_INC   = 4'h8, OP_DEC  = 4'h9, OP_RLF  = 4'hA, OP_RRF   = 4'hB,
    OP_SWAP  = 4'hC, OP_BCF  = 4'hD, OP_BSF  = 4'hE, OP_PASSW = 4'hF
  } alu_op_e;

  alu_op_e    op;
  logic [7:0] res;
  logic [8:0] sum9;
  logic [7:0] mask;
  logic       carry_d, carry_q;
  logic       zero_d, zero_q;

  // inst_reg[0] carries no meaning for the execute stage
  logic       unused_inst_bit;
  assign unused_inst_bit = inst_reg[0];

  // Instruction decode: ALU op, destination and B-operand select
  always_comb begin
    op         = OP_MOV;
    d          = inst_reg[1];
    switch_a_m = 1'b0;
    bit_number = inst_reg[3:1];
    unique case (inst_reg[7:6])
      2'b00: begin
        unique case (inst_reg[5:2])
          4'b0000: begin op = OP_PASSW; d = 1'b1; end // MOVWF
          4'b0001: op = OP_CLR;
          4'b0010: op = OP_SUB;
          4'b0011: op = OP_DEC;
          4'b0100: op = OP_IOR;
          4'b0101: op = OP_AND;
          4'b0110: op = OP_XOR;
          4'b0111: op = OP_ADD;
          4'b1000: op = OP_MOV;
          4'b1001: op = OP_COM;
          4'b1010: op = OP_INC;
          4'b1011: op = OP_DEC;
          4'b1100: op = OP_RRF;
          4'b1101: op = OP_RLF;
          4'b1110: op = OP_SWAP;
          default: op = OP_INC;
        endcase
      end
      2'b01: begin
        d = 1'b1;
        unique case (inst_reg[5:4])
          2'b00:   op = OP_BCF;
          2'b01:   op = OP_BSF;
          default: op = OP_MOV; // bit tests just read the file
        endcase
      end
      2'b10: begin // call/goto: W passes through untouched
        op         = OP_PASSW;
        d          = 1'b0;
        switch_a_m = 1'b1;
      end
      default: begin
        d          = 1'b0;
        switch_a_m = 1'b1;
        casez (inst_reg[5:2])
          4'b0???: op = OP_MOV;
          4'b1000: op = OP_IOR;
          4'b1001: op = OP_AND;
          4'b1010: op = OP_XOR;
          4'b1011: op = OP_PASSW;
          4'b110?: op = OP_SUB;
          default: op = OP_ADD;
        endcase
      end
    endcase
  end

  assign inst = op;
  assign b    = switch_a_m ? k : f;
  assign mask = 8'h01 << bit_number;
  assign sum9 = {1'b0, w} + {1'b0, b};

  // ALU result and next-state flags; flags hold unless the op defines them
  always_comb begin
    res     = 8'h00;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (op)
      OP_ADD:   begin res = sum9[7:0]; carry_d = sum9[8]; end
      OP_SUB:   begin res = b - w;     carry_d = (b >= w); end
      OP_AND:   res = w & b;
      OP_IOR:   res = w | b;
      OP_XOR:   res = w ^ b;
      OP_COM:   res = ~b;
      OP_CLR:   res = 8'h00;
      OP_MOV:   res = b;
      OP_INC:   res = b + 8'h01;
      OP_DEC:   res = b - 8'h01;
      OP_RLF:   begin res = {b[6:0], carry_q}; carry_d = b[7]; end
      OP_RRF:   begin res = {carry_q, b[7:1]}; carry_d = b[0]; end
      OP_SWAP:  res = {b[3:0], b[7:4]};
      OP_BCF:   res = b & ~mask;
      OP_BSF:   res = b | mask;
      default:  res = w;
    endcase
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_IOR, OP_XOR, OP_COM, OP_CLR, OP_MOV,
      OP_INC, OP_DEC: zero_d = (res == 8'h00);
      default: ;
    endcase
  end

  assign ans   = reset ? 8'h00 : res;
  assign carry = carry_q;
  assign zero  = zero_q;

  // Flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_pic_exec_core.sv
// Directed bench for pic_exec_core: expectations are queued when a step is
// driven and popped/compared once the DUT output for that step is sampled.
module tb_pic_exec_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] inst_reg, f, k, w;
  logic [7:0] ans, b;
  logic       d, carry, zero, switch_a_m;
  logic [3:0] inst;
  logic [2:0] bit_number;

  pic_exec_core dut (
    .clk(clk), .reset(reset), .inst_reg(inst_reg), .f(f), .k(k), .w(w),
    .ans(ans), .d(d), .carry(carry), .zero(zero), .inst(inst),
    .bit_number(bit_number), .switch_a_m(switch_a_m), .b(b)
  );

  always #5 clk = ~clk;

  localparam int S_ANS = 0, S_D = 1, S_C = 2, S_Z = 3, S_B = 4, S_SW = 5,
                 S_BIT = 6, S_INST = 7;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic expect_v(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      S_ANS:   return ans;
      S_D:     return {7'd0, d};
      S_C:     return {7'd0, carry};
      S_Z:     return {7'd0, zero};
      S_B:     return b;
      S_SW:    return {7'd0, switch_a_m};
      S_BIT:   return {5'd0, bit_number};
      default: return {4'd0, inst};
    endcase
  endfunction

  task automatic check_all();
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] o;
      e = sb.pop_front();
      o = observe(e.sel);
      n_cmp++;
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  // Apply inputs just after an edge, then settle before the comb checks
  task automatic drive(input logic [7:0] i, input logic [7:0] wv,
                       input logic [7:0] fv, input logic [7:0] kv);
    inst_reg = i; w = wv; f = fv; k = kv;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(8'b00011101, 8'hFF, 8'h01, 8'h00);
    expect_v("reset_ans", S_ANS, 8'h00);
    check_all();
    tick();
    expect_v("reset_c", S_C, 8'h0); expect_v("reset_z", S_Z, 8'h0);
    check_all();
    reset = 1'b0;

    // ADD w+f
    drive(8'b00011101, 8'd5, 8'd10, 8'h00);
    expect_v("add_b", S_B, 8'd10); expect_v("add_d", S_D, 8'h0);
    expect_v("add_sw", S_SW, 8'h0); expect_v("add_ans", S_ANS, 8'd15);
    expect_v("add_inst", S_INST, 8'h0);
    check_all();
    tick();
    expect_v("add_c", S_C, 8'h0); expect_v("add_z", S_Z, 8'h0);
    check_all();
    drive(8'b00011101, 8'hF0, 8'h20, 8'h00);
    expect_v("add_ovf_ans", S_ANS, 8'h10);
    check_all();
    tick();
    expect_v("add_ovf_c", S_C, 8'h1); expect_v("add_ovf_z", S_Z, 8'h0);
    check_all();

    // SUB f-w
    drive(8'b00001001, 8'd15, 8'd10, 8'h00);
    expect_v("sub_ans", S_ANS, 8'hFB); expect_v("sub_inst", S_INST, 8'h1);
    check_all();
    tick();
    expect_v("sub_c", S_C, 8'h0);
    check_all();
    drive(8'b00001001, 8'd10, 8'd10, 8'h00);
    expect_v("sub_eq_ans", S_ANS, 8'h00);
    check_all();
    tick();
    expect_v("sub_eq_c", S_C, 8'h1); expect_v("sub_eq_z", S_Z, 8'h1);
    check_all();

    // SWAP holds flags, COM sets Z from result
    drive(8'b00111001, 8'h00, 8'h3C, 8'h00);
    expect_v("swap_ans", S_ANS, 8'hC3);
    check_all();
    tick();
    expect_v("swap_hold_c", S_C, 8'h1); expect_v("swap_hold_z", S_Z, 8'h1);
    check_all();
    drive(8'b00100101, 8'h00, 8'h00, 8'h00);
    expect_v("com_ans", S_ANS, 8'hFF); expect_v("com_d", S_D, 8'h0);
    check_all();
    tick();
    expect_v("com_z", S_Z, 8'h0); expect_v("com_c", S_C, 8'h1);
    check_all();

    // BSF / BCF and bit test
    drive(8'b01010100, 8'h00, 8'h00, 8'h00);
    expect_v("bsf_bit", S_BIT, 8'd2); expect_v("bsf_d", S_D, 8'h1);
    expect_v("bsf_ans", S_ANS, 8'h04);
    check_all();
    drive(8'b01000100, 8'h00, 8'h04, 8'h00);
    expect_v("bcf_ans", S_ANS, 8'h00);
    check_all();
    drive(8'b01001110, 8'h00, 8'hFF, 8'h00);
    expect_v("bcf7_ans", S_ANS, 8'h7F);
    check_all();
    drive(8'b01100000, 8'h00, 8'h5A, 8'h00);
    expect_v("btst_ans", S_ANS, 8'h5A); expect_v("btst_d", S_D, 8'h1);
    check_all();
    tick();
    expect_v("bit_hold_c", S_C, 8'h1); expect_v("bit_hold_z", S_Z, 8'h0);
    check_all();

    // RLF with C=1, then RRF with C=0
    drive(8'b00110100, 8'h00, 8'h40, 8'h00);
    expect_v("rlf_ans", S_ANS, 8'h81);
    check_all();
    tick();
    expect_v("rlf_c", S_C, 8'h0);
    check_all();
    drive(8'b00110000, 8'h00, 8'h01, 8'h00);
    expect_v("rrf_ans", S_ANS, 8'h00);
    check_all();
    tick();
    expect_v("rrf_c", S_C, 8'h1); expect_v("rrf_z_hold", S_Z, 8'h0);
    check_all();

    // INC / DEC wrap
    drive(8'b00101000, 8'h00, 8'hFF, 8'h00);
    expect_v("inc_wrap_ans", S_ANS, 8'h00);
    check_all();
    tick();
    expect_v("inc_wrap_z", S_Z, 8'h1); expect_v("inc_wrap_c", S_C, 8'h1);
    check_all();
    drive(8'b00001100, 8'h00, 8'h00, 8'h00);
    expect_v("dec_wrap_ans", S_ANS, 8'hFF);
    check_all();
    tick();
    expect_v("dec_wrap_z", S_Z, 8'h0);
    check_all();

    // MOVWF forces d=1 and holds flags; CLR sets Z
    drive(8'b00000000, 8'h5A, 8'h00, 8'h00);
    expect_v("movwf_ans", S_ANS, 8'h5A); expect_v("movwf_d", S_D, 8'h1);
    expect_v("movwf_inst", S_INST, 8'hF);
    check_all();
    tick();
    expect_v("movwf_z_hold", S_Z, 8'h0);
    check_all();
    drive(8'b00000110, 8'h5A, 8'h33, 8'h00);
    expect_v("clr_ans", S_ANS, 8'h00); expect_v("clr_d", S_D, 8'h1);
    check_all();
    tick();
    expect_v("clr_z", S_Z, 8'h1);
    check_all();

    // Logic ops
    drive(8'b00011000, 8'hF0, 8'hFF, 8'h00);
    expect_v("xor_ans", S_ANS, 8'h0F);
    check_all();
    drive(8'b00010000, 8'h0F, 8'hF0, 8'h00);
    expect_v("ior_ans", S_ANS, 8'hFF);
    check_all();
    drive(8'b00010100, 8'h0F, 8'h3C, 8'h00);
    expect_v("and_ans", S_ANS, 8'h0C);
    check_all();
    tick();
    expect_v("and_z", S_Z, 8'h0);
    check_all();

    // Literal class
    drive(8'b11000000, 8'h00, 8'hAA, 8'h01);
    expect_v("movlw_sw", S_SW, 8'h1); expect_v("movlw_b", S_B, 8'h01);
    expect_v("movlw_ans", S_ANS, 8'h01); expect_v("movlw_d", S_D, 8'h0);
    check_all();
    drive(8'b11111000, 8'hFF, 8'hAA, 8'h01);
    expect_v("addlw_ans", S_ANS, 8'h00);
    check_all();
    tick();
    expect_v("addlw_c", S_C, 8'h1); expect_v("addlw_z", S_Z, 8'h1);
    check_all();
    drive(8'b11101100, 8'h44, 8'h00, 8'h99);
    expect_v("passw_l_ans", S_ANS, 8'h44);
    check_all();
    drive(8'b11110000, 8'h20, 8'h00, 8'h10);
    expect_v("sublw_ans", S_ANS, 8'hF0);
    check_all();
    tick();
    expect_v("sublw_c", S_C, 8'h0); expect_v("sublw_z", S_Z, 8'h0);
    check_all();

    // call/goto class
    drive(8'b10110101, 8'h33, 8'h00, 8'h77);
    expect_v("goto_sw", S_SW, 8'h1); expect_v("goto_b", S_B, 8'h77);
    expect_v("goto_d", S_D, 8'h0); expect_v("goto_ans", S_ANS, 8'h33);
    check_all();

    // Set both flags, then reset clears them
    drive(8'b11111000, 8'hFF, 8'h00, 8'h01);
    tick();
    expect_v("pre_rst_c", S_C, 8'h1); expect_v("pre_rst_z", S_Z, 8'h1);
    check_all();
    reset = 1'b1;
    drive(8'b00011101, 8'd5, 8'd10, 8'h00);
    expect_v("rst2_ans", S_ANS, 8'h00);
    check_all();
    tick();
    expect_v("rst2_c", S_C, 8'h0); expect_v("rst2_z", S_Z, 8'h0);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
